// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit stage.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; no push-through, so a pushed word is
// visible at pop_data only on the cycle after it is written.
module sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("sync_fifo: DEPTH must be a power of two in 2..16");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap for free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_stage.sv
// 8N1 UART transmitter fed from a small byte FIFO; frames go out LSB first and
// back-to-back while the FIFO stays non-empty.
module uart_tx_stage
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [7:0]                        in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_BIT    = IW'(UART_DATA_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_cpb_chk
    $error("uart_tx_stage: CLKS_PER_BIT must be >= 2");
  end

  uart_tx_state_t            state, state_d;
  logic [BW-1:0]             baud_cnt, baud_cnt_d;
  logic [IW-1:0]             bit_idx, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift, shift_d;
  logic                      tx_d;
  logic                      busy_d;
  logic                      push;
  logic                      pop;
  logic                      bit_end;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [7:0]                fifo_data;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign bit_end  = (baud_cnt == '0);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      shift    <= shift_d;
      tx       <= tx_d;
      busy     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shift_d    = shift;
    pop        = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_d    = fifo_data;
          baud_cnt_d = BAUD_RELOAD;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_d = BAUD_RELOAD;
          bit_idx_d  = '0;
          state_d    = DATA;
        end else begin
          baud_cnt_d = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_d = BAUD_RELOAD;
          shift_d    = shift >> 1;
          if (bit_idx == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 1'b1;
          end
        end else begin
          baud_cnt_d = baud_cnt - 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_d = BAUD_RELOAD;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_data;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx and busy are registered from next-state values so the line level
  // changes on the same edge as the state it belongs to.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) || push || (fifo_count > CW'(pop));
  end

endmodule
